// File: rtl/gnr_attractor_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gnr_attractor_ctrl_pkg
// Shared definitions for the gene-regulatory-network attractor controller:
// the controller FSM encoding and the default counter width.
// -----------------------------------------------------------------------------
package gnr_attractor_ctrl_pkg;

    localparam int GNR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_STEP,
        ST_CHECK,
        ST_PSTEP,
        ST_PCHECK,
        ST_FIN
    } gnr_state_e;

endpackage

// File: rtl/gnr_attractor_ctrl_step_counter.sv
// -----------------------------------------------------------------------------
// gnr_step_counter
// Clearable up-counter with a compare-to-limit flag. Saturates at the limit
// so it can never wrap.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_i      synchronous clear (wins over increment)
//   inc_i        increment by one
//   limit_i      comparison limit
//   count_o      current count
//   at_limit_o   count_o == limit_i
// -----------------------------------------------------------------------------
module gnr_step_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_limit_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign at_limit_o = (count_q == limit_i);
    assign count_o    = count_q;

    // NOTE: combinational next-state gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !at_limit_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// -----------------------------------------------------------------------------
// gnr_attractor_ctrl
// Drives two copies of a boolean network (slow s0, fast s1) to find an
// attractor: steps both copies until their states meet at an even step
// index, then steps only s1 until it returns to s0, giving the cycle length.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                run request (only honoured in IDLE)
//   seed, max_steps      initial state and per-phase step budget
//   s0_state, s1_state   node outputs of the slow / fast copies
//   reset_nos            one-cycle load of init_state into the nodes
//   init_state           captured seed driven to the nodes
//   start_s0, start_s1   step pulses to the two copies
//   busy, done, timeout  run status; done is a one-cycle pulse
//   meet_steps, period   results, held until the next accepted start
// -----------------------------------------------------------------------------
module gnr_attractor_ctrl
    import gnr_attractor_ctrl_pkg::*;
#(
    parameter int N_NODES = 8,
    parameter int CNT_W   = GNR_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_NODES-1:0] seed,
    input  logic [CNT_W-1:0]   max_steps,
    input  logic [N_NODES-1:0] s0_state,
    input  logic [N_NODES-1:0] s1_state,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period
);

    gnr_state_e         state_q;
    logic [N_NODES-1:0] seed_q;
    logic [CNT_W-1:0]   limit_q;
    logic               reset_nos_q;
    logic               start_s0_q;
    logic               start_s1_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   meet_q;
    logic [CNT_W-1:0]   period_q;

    logic               accept;
    logic [CNT_W-1:0]   k_cnt;
    logic [CNT_W-1:0]   p_cnt;
    logic               k_at_lim;
    logic               p_at_lim;
    logic               match;

    assign accept = (state_q == ST_IDLE) && start;
    assign match  = (s0_state == s1_state);

    gnr_step_counter #(.CNT_W(CNT_W)) u_k_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (accept),
        .inc_i      (state_q == ST_STEP),
        .limit_i    (limit_q),
        .count_o    (k_cnt),
        .at_limit_o (k_at_lim)
    );

    gnr_step_counter #(.CNT_W(CNT_W)) u_p_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (accept),
        .inc_i      (state_q == ST_PSTEP),
        .limit_i    (limit_q),
        .count_o    (p_cnt),
        .at_limit_o (p_at_lim)
    );

    // Outputs are registered: each is set on the transition into the state
    // in which it must be visible, and pulses default back to 0 every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            seed_q      <= '0;
            limit_q     <= '0;
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            meet_q      <= '0;
            period_q    <= '0;
        end else begin
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        seed_q      <= seed;
                        // A zero budget still allows one step.
                        limit_q     <= (max_steps == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : max_steps;
                        timeout_q   <= 1'b0;
                        meet_q      <= '0;
                        period_q    <= '0;
                        busy_q      <= 1'b1;
                        reset_nos_q <= 1'b1;
                        state_q     <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    start_s0_q <= 1'b1;
                    start_s1_q <= 1'b1;
                    state_q    <= ST_STEP;
                end
                ST_STEP: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    // At odd k the slow copy has taken one step too many, so
                    // equality there means nothing.
                    if (!k_cnt[0] && match) begin
                        meet_q     <= k_cnt;
                        start_s1_q <= 1'b1;
                        state_q    <= ST_PSTEP;
                    end else if (k_at_lim) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= ST_FIN;
                    end else begin
                        start_s0_q <= 1'b1;
                        start_s1_q <= 1'b1;
                        state_q    <= ST_STEP;
                    end
                end
                ST_PSTEP: begin
                    state_q <= ST_PCHECK;
                end
                ST_PCHECK: begin
                    if (match) begin
                        period_q <= p_cnt;
                        done_q   <= 1'b1;
                        state_q  <= ST_FIN;
                    end else if (p_at_lim) begin
                        timeout_q <= 1'b1;
                        period_q  <= '0;
                        done_q    <= 1'b1;
                        state_q   <= ST_FIN;
                    end else begin
                        start_s1_q <= 1'b1;
                        state_q    <= ST_PSTEP;
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign reset_nos  = reset_nos_q;
    assign init_state = seed_q;
    assign start_s0   = start_s0_q;
    assign start_s1   = start_s1_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign meet_steps = meet_q;
    assign period     = period_q;

endmodule
